// File: rtl/bu_exec_pkg.sv
// Shared types and constants for the branch execution unit.
// Widths, opcode/func3 encodings, FSM states, RS entry and result records.
package bu_exec_pkg;

    localparam int XLEN   = 32;
    localparam int PREG_W = 7;
    localparam int ROB_W  = 5;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        BU_IDLE,
        BU_READ,
        BU_EXEC,
        BU_WB
    } bu_state_t;

    typedef struct packed {
        logic [6:0]        Opcode;
        logic [2:0]        func3;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [XLEN-1:0]   imm;
        logic [ROB_W-1:0]  rob_index;
        logic [XLEN-1:0]   pc;
    } rs_data;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_index;
        logic [PREG_W-1:0] pd;
        logic              pd_valid;
        logic [XLEN-1:0]   data;
        logic              mispredict;
        logic [XLEN-1:0]   target;
    } bu_result;

endpackage

// File: rtl/bu_exec_if.sv
// Issue, PRF-read, writeback and redirect signals of the branch unit.
// slave = the branch unit itself, master = RS/PRF/ROB environment.
interface bu_exec_if;
    import bu_exec_pkg::*;

    logic              issue_valid;
    rs_data            issue_data;
    logic              fu_rdy;
    logic [PREG_W-1:0] prf_raddr1;
    logic [PREG_W-1:0] prf_raddr2;
    logic [XLEN-1:0]   prf_rdata1;
    logic [XLEN-1:0]   prf_rdata2;
    logic              wb_valid;
    logic              wb_ack;
    logic [ROB_W-1:0]  wb_rob_index;
    logic [PREG_W-1:0] wb_pd;
    logic              wb_pd_valid;
    logic [XLEN-1:0]   wb_data;
    logic              wb_mispredict;
    logic              flush;
    logic [ROB_W-1:0]  flush_tag;
    logic [XLEN-1:0]   flush_pc;
    logic              flush_in;

    modport slave (
        input  issue_valid, issue_data, prf_rdata1, prf_rdata2, wb_ack, flush_in,
        output fu_rdy, prf_raddr1, prf_raddr2, wb_valid, wb_rob_index, wb_pd,
               wb_pd_valid, wb_data, wb_mispredict, flush, flush_tag, flush_pc
    );

    modport master (
        output issue_valid, issue_data, prf_rdata1, prf_rdata2, wb_ack, flush_in,
        input  fu_rdy, prf_raddr1, prf_raddr2, wb_valid, wb_rob_index, wb_pd,
               wb_pd_valid, wb_data, wb_mispredict, flush, flush_tag, flush_pc
    );

endinterface

// File: rtl/bu_exec_cmp.sv
// Branch condition evaluator: decides taken/not-taken from func3.
// Reserved func3 encodings (010, 011) resolve as not taken.
module bu_cmp
    import bu_exec_pkg::*;
(
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [2:0]      func3_i,
    output logic            taken_o
);

    // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
    always_comb begin
        taken_o = 1'b0;
        case (func3_i)
            F3_BEQ:  taken_o = (op1_i == op2_i);
            F3_BNE:  taken_o = (op1_i != op2_i);
            F3_BLT:  taken_o = ($signed(op1_i) <  $signed(op2_i));
            F3_BGE:  taken_o = ($signed(op1_i) >= $signed(op2_i));
            F3_BLTU: taken_o = (op1_i <  op2_i);
            F3_BGEU: taken_o = (op1_i >= op2_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/bu_exec.sv
// Branch execution unit: IDLE -> READ -> EXEC -> WB, one op in flight.
// Every taken branch and every jump redirects the not-taken front end.
module bu_exec
    import bu_exec_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    bu_exec_if.slave bus
);

    bu_state_t         state_q, state_d;
    logic              flush_q, flush_d;
    logic [6:0]        opcode_q;
    logic [2:0]        func3_q;
    logic [PREG_W-1:0] pd_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   pc_q;
    logic [ROB_W-1:0]  rob_q;
    logic [XLEN-1:0]   op1_q;
    logic [XLEN-1:0]   op2_q;
    bu_result          res_q, res_d;
    logic              cmp_taken;

    bu_cmp u_cmp (
        .op1_i   (op1_q),
        .op2_i   (op2_q),
        .func3_i (func3_q),
        .taken_o (cmp_taken)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BU_IDLE;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    // flush_q marks the first WB cycle of a taken op; that cycle our own redirect beats flush_in.
    always_comb begin
        state_d = state_q;
        case (state_q)
            BU_IDLE: if (bus.issue_valid && !bus.flush_in) state_d = BU_READ;
            BU_READ: state_d = bus.flush_in ? BU_IDLE : BU_EXEC;
            BU_EXEC: state_d = bus.flush_in ? BU_IDLE : BU_WB;
            BU_WB:   if (bus.wb_ack || (bus.flush_in && !flush_q)) state_d = BU_IDLE;
            default: state_d = BU_IDLE;
        endcase
    end

    always_comb begin
        res_d           = '0;
        res_d.rob_index = rob_q;
        res_d.pd        = pd_q;
        res_d.data      = pc_q + XLEN'(4);
        res_d.target    = pc_q + imm_q;
        case (opcode_q)
            OP_BRANCH: res_d.mispredict = cmp_taken;
            OP_JAL: begin
                res_d.mispredict = 1'b1;
                res_d.pd_valid   = (pd_q != '0);
            end
            OP_JALR: begin
                res_d.mispredict = 1'b1;
                res_d.pd_valid   = (pd_q != '0);
                res_d.target     = (op1_q + imm_q) & ~XLEN'(1);
            end
            default: ;
        endcase
    end

    assign flush_d = (state_q == BU_EXEC) && !bus.flush_in && res_d.mispredict;

    // NOTE: datapath registers are reset too, so outputs derived from them read zero out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opcode_q <= '0;
            func3_q  <= '0;
            pd_q     <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            rob_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            res_q    <= '0;
        end else begin
            if (state_q == BU_IDLE && bus.issue_valid && !bus.flush_in) begin
                opcode_q <= bus.issue_data.Opcode;
                func3_q  <= bus.issue_data.func3;
                pd_q     <= bus.issue_data.pd;
                imm_q    <= bus.issue_data.imm;
                pc_q     <= bus.issue_data.pc;
                rob_q    <= bus.issue_data.rob_index;
            end
            if (state_q == BU_READ) begin
                op1_q <= bus.prf_rdata1;
                op2_q <= bus.prf_rdata2;
            end
            if (state_q == BU_EXEC && !bus.flush_in) res_q <= res_d;
        end
    end

    always_comb begin
        bus.fu_rdy        = (state_q == BU_IDLE);
        bus.prf_raddr1    = bus.issue_data.ps1;
        bus.prf_raddr2    = bus.issue_data.ps2;
        bus.wb_valid      = (state_q == BU_WB);
        bus.wb_rob_index  = res_q.rob_index;
        bus.wb_pd         = res_q.pd;
        bus.wb_pd_valid   = res_q.pd_valid;
        bus.wb_data       = res_q.data;
        bus.wb_mispredict = res_q.mispredict;
        bus.flush         = flush_q;
        bus.flush_tag     = res_q.rob_index;
        bus.flush_pc      = res_q.target;
    end

    a_issue_when_ready: assert property (@(posedge clk) disable iff (reset)
        bus.issue_valid |-> bus.fu_rdy);

endmodule

// File: tb/tb_bu_exec.sv
// Self-checking bench for bu_exec: directed vector table, random ops
// against a behavioural model, and hand-written flush/ack/reset sequences.
module tb_bu_exec;
    import bu_exec_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [XLEN-1:0] prf [128];

    bu_exec_if bus();

    bu_exec dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // PRF with one-cycle synchronous read
    always @(posedge clk) begin
        bus.prf_rdata1 <= prf[bus.prf_raddr1];
        bus.prf_rdata2 <= prf[bus.prf_raddr2];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [31:0] op1, op2, pc, imm;
        logic [6:0]  pd;
        logic [4:0]  rob;
        logic        exp_taken;
        logic [31:0] exp_pc;
        logic        exp_pdv;
        logic [31:0] exp_data;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level reference: direction, redirect target, link.
    task automatic model(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] op1, op2, pc, imm, input logic [6:0] pd,
                         output logic taken, output logic [31:0] target,
                         output logic pdv, output logic [31:0] link);
        longint unsigned sum;
        sum    = (longint'(pc) + longint'(imm)) % 64'h1_0000_0000;
        target = 32'(sum);
        link   = 32'((longint'(pc) + 4) % 64'h1_0000_0000);
        taken  = 1'b0;
        pdv    = 1'b0;
        if (opc == 7'b1100011) begin
            if      (f3 == 3'd0) taken = (op1 == op2);
            else if (f3 == 3'd1) taken = (op1 != op2);
            else if (f3 == 3'd4) taken = (int'(op1) <  int'(op2));
            else if (f3 == 3'd5) taken = (int'(op1) >= int'(op2));
            else if (f3 == 3'd6) taken = (longint'(op1) <  longint'(op2));
            else if (f3 == 3'd7) taken = (longint'(op1) >= longint'(op2));
        end else if (opc == 7'b1101111 || opc == 7'b1100111) begin
            taken = 1'b1;
            pdv   = (pd != 0);
            if (opc == 7'b1100111) begin
                sum    = (longint'(op1) + longint'(imm)) % 64'h1_0000_0000;
                target = 32'(sum) - 32'(sum % 2);
            end
        end
    endtask

    // Called at a negedge in IDLE; returns at the next negedge (unit in READ).
    task automatic issue(input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] op1, op2, pc, imm,
                         input logic [6:0] pd, input logic [4:0] rob);
        logic [6:0] ps1;
        ps1 = 7'($urandom_range(1, 125));
        prf[ps1]     = op1;
        prf[ps1 + 1] = op2;
        bus.issue_data.Opcode    = opc;
        bus.issue_data.func3     = f3;
        bus.issue_data.pd        = pd;
        bus.issue_data.ps1       = ps1;
        bus.issue_data.ps2       = ps1 + 7'd1;
        bus.issue_data.imm       = imm;
        bus.issue_data.rob_index = rob;
        bus.issue_data.pc        = pc;
        bus.issue_valid          = 1'b1;
        @(negedge clk);
        bus.issue_valid = 1'b0;
    endtask

    // Waits for WB, checks it, holds wb_ack low for 'hold' extra cycles, then acks.
    task automatic expect_wb(input string nm, input logic taken, input logic [31:0] tgt,
                             input logic pdv, input logic [6:0] pd, input logic [31:0] link,
                             input logic [4:0] rob, input int hold);
        int n = 1;
        while (!bus.wb_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({nm, " latency"}, n, 3);
        if (!bus.wb_valid) return;
        check({nm, " flush"}, bus.flush, taken);
        if (taken) begin
            check({nm, " flush_pc"}, bus.flush_pc, tgt);
            check({nm, " flush_tag"}, bus.flush_tag, rob);
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                @(negedge clk);
                check({nm, " flush after first wb"}, bus.flush, 0);
            end
            check({nm, " wb_valid"}, bus.wb_valid, 1);
            check({nm, " fu_rdy in wb"}, bus.fu_rdy, 0);
            check({nm, " wb_mispredict"}, bus.wb_mispredict, taken);
            check({nm, " wb_pd_valid"}, bus.wb_pd_valid, pdv);
            if (pdv) check({nm, " wb_pd"}, bus.wb_pd, pd);
            check({nm, " wb_data"}, bus.wb_data, link);
            check({nm, " wb_rob_index"}, bus.wb_rob_index, rob);
        end
        bus.wb_ack = 1'b1;
        @(negedge clk);
        bus.wb_ack = 1'b0;
        check({nm, " fu_rdy after ack"}, bus.fu_rdy, 1);
        check({nm, " wb_valid after ack"}, bus.wb_valid, 0);
        check({nm, " flush after ack"}, bus.flush, 0);
    endtask

    vec_t vecs [$];

    initial begin
        logic        m_taken, m_pdv;
        logic [31:0] m_tgt, m_link;

        vecs.push_back('{"beq_eq",    OP_BRANCH, 3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 7'd0, 5'd3, 1, 32'h120, 0, 32'h104});
        vecs.push_back('{"blt_neg",   OP_BRANCH, 3'b100, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 7'd0, 5'd4, 1, 32'h210, 0, 32'h204});
        vecs.push_back('{"bltu_big",  OP_BRANCH, 3'b110, 32'hFFFFFFFF, 32'd1, 32'h200, 32'h10, 7'd0, 5'd4, 0, 32'h0, 0, 32'h204});
        vecs.push_back('{"jalr_pd9",  OP_JALR,   3'b000, 32'h1001, 32'd0, 32'h40, 32'd2, 7'd9, 5'd5, 1, 32'h1002, 1, 32'h44});
        vecs.push_back('{"jalr_pd0",  OP_JALR,   3'b000, 32'h1001, 32'd0, 32'h40, 32'd2, 7'd0, 5'd6, 1, 32'h1002, 0, 32'h44});
        vecs.push_back('{"jalr_odd",  OP_JALR,   3'b000, 32'h2000, 32'd0, 32'h80, 32'd7, 7'd1, 5'd2, 1, 32'h2006, 1, 32'h84});
        vecs.push_back('{"jal_wrap",  OP_JAL,    3'b000, 32'd0, 32'd0, 32'hFFFFFFF0, 32'h20, 7'd1, 5'd7, 1, 32'h10, 1, 32'hFFFFFFF4});
        vecs.push_back('{"bne_eq",    OP_BRANCH, 3'b001, 32'd3, 32'd3, 32'h300, 32'h8, 7'd0, 5'd8, 0, 32'h0, 0, 32'h304});
        vecs.push_back('{"bge_neg",   OP_BRANCH, 3'b101, 32'h80000000, 32'd0, 32'h300, 32'hFFFFFFF0, 7'd0, 5'd9, 0, 32'h0, 0, 32'h304});
        vecs.push_back('{"bgeu_big",  OP_BRANCH, 3'b111, 32'h80000000, 32'd0, 32'h300, 32'hFFFFFFF0, 7'd0, 5'd10, 1, 32'h2F0, 0, 32'h304});
        vecs.push_back('{"bad_f3",    OP_BRANCH, 3'b010, 32'd7, 32'd7, 32'h400, 32'h4, 7'd0, 5'd11, 0, 32'h0, 0, 32'h404});
        vecs.push_back('{"bad_opc",   7'b0110011, 3'b000, 32'd7, 32'd7, 32'h500, 32'h4, 7'd3, 5'd12, 0, 32'h0, 0, 32'h504});

        bus.issue_valid = 1'b0;
        bus.issue_data  = '0;
        bus.wb_ack      = 1'b0;
        bus.flush_in    = 1'b0;
        for (int i = 0; i < 128; i++) prf[i] = '0;
        repeat (3) @(negedge clk);
        check("reset fu_rdy", bus.fu_rdy, 1);
        check("reset wb_valid", bus.wb_valid, 0);
        check("reset flush", bus.flush, 0);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            issue(vecs[i].opc, vecs[i].f3, vecs[i].op1, vecs[i].op2, vecs[i].pc, vecs[i].imm,
                  vecs[i].pd, vecs[i].rob);
            expect_wb(vecs[i].name, vecs[i].exp_taken, vecs[i].exp_pc, vecs[i].exp_pdv,
                      vecs[i].pd, vecs[i].exp_data, vecs[i].rob, (i == 0) ? 5 : 0);
        end

        // flush_in during EXEC abandons the op
        issue(OP_BRANCH, F3_BEQ, 32'd1, 32'd1, 32'h600, 32'h40, 7'd0, 5'd13);
        @(negedge clk);
        bus.flush_in = 1'b1;
        @(negedge clk);
        bus.flush_in = 1'b0;
        check("exec flush_in fu_rdy", bus.fu_rdy, 1);
        for (int i = 0; i < 4; i++) begin
            check("exec flush_in wb_valid", bus.wb_valid, 0);
            check("exec flush_in flush", bus.flush, 0);
            @(negedge clk);
        end

        // flush_in during READ abandons the op
        issue(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h700, 32'h40, 7'd2, 5'd14);
        bus.flush_in = 1'b1;
        @(negedge clk);
        bus.flush_in = 1'b0;
        check("read flush_in fu_rdy", bus.fu_rdy, 1);
        repeat (3) begin
            @(negedge clk);
            check("read flush_in wb_valid", bus.wb_valid, 0);
        end

        // flush_in coincident with issue in IDLE: issue ignored
        bus.flush_in = 1'b1;
        issue(OP_JAL, 3'b000, 32'd0, 32'd0, 32'h700, 32'h40, 7'd2, 5'd15);
        bus.flush_in = 1'b0;
        check("idle flush_in fu_rdy", bus.fu_rdy, 1);
        repeat (3) begin
            @(negedge clk);
            check("idle flush_in wb_valid", bus.wb_valid, 0);
        end

        // flush_in in first WB cycle of a taken op: own flush wins, op waits for ack
        issue(OP_BRANCH, F3_BEQ, 32'd9, 32'd9, 32'h800, 32'h10, 7'd0, 5'd16);
        @(negedge clk);
        @(negedge clk);
        bus.flush_in = 1'b1;
        check("wb1 flush_in own flush", bus.flush, 1);
        check("wb1 flush_in flush_pc", bus.flush_pc, 32'h810);
        @(negedge clk);
        bus.flush_in = 1'b0;
        check("wb1 flush_in wb_valid held", bus.wb_valid, 1);
        check("wb1 flush_in flush once", bus.flush, 0);
        bus.wb_ack = 1'b1;
        @(negedge clk);
        bus.wb_ack = 1'b0;
        check("wb1 flush_in fu_rdy", bus.fu_rdy, 1);

        // flush_in in WB of a not-taken op abandons it
        issue(OP_BRANCH, F3_BNE, 32'd9, 32'd9, 32'h900, 32'h10, 7'd0, 5'd17);
        @(negedge clk);
        @(negedge clk);
        check("nt wb_valid", bus.wb_valid, 1);
        bus.flush_in = 1'b1;
        @(negedge clk);
        bus.flush_in = 1'b0;
        check("nt flush_in wb_valid", bus.wb_valid, 0);
        check("nt flush_in fu_rdy", bus.fu_rdy, 1);

        // wb_ack before wb_valid is ignored
        issue(OP_JAL, 3'b000, 32'd0, 32'd0, 32'hA00, 32'h8, 7'd4, 5'd18);
        bus.wb_ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.wb_ack = 1'b0;
        check("early ack wb_valid", bus.wb_valid, 1);
        @(negedge clk);
        check("early ack wb_valid held", bus.wb_valid, 1);
        check("early ack wb_data", bus.wb_data, 32'hA04);
        bus.wb_ack = 1'b1;
        @(negedge clk);
        bus.wb_ack = 1'b0;
        check("early ack fu_rdy", bus.fu_rdy, 1);

        // asynchronous reset in READ
        issue(OP_JAL, 3'b000, 32'd0, 32'd0, 32'hB00, 32'h30, 7'd5, 5'd19);
        #2 reset = 1'b1;
        #1;
        check("async reset fu_rdy", bus.fu_rdy, 1);
        check("async reset wb_valid", bus.wb_valid, 0);
        check("async reset flush", bus.flush, 0);
        check("async reset flush_pc", bus.flush_pc, 0);
        check("async reset wb_data", bus.wb_data, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(OP_BRANCH, F3_BLT, 32'hFFFFFFFE, 32'h0, 32'hC00, 32'h100, 7'd0, 5'd20);
        expect_wb("after reset", 1, 32'hD00, 0, 7'd0, 32'hC04, 5'd20, 1);

        // random ops against the model
        for (int k = 0; k < 80; k++) begin
            logic [6:0]  opc, pd;
            logic [2:0]  f3;
            logic [31:0] a, b, pc, imm;
            logic [4:0]  rob;
            int          sel;
            sel = $urandom_range(0, 9);
            opc = (sel < 6) ? OP_BRANCH : (sel == 6) ? OP_JAL : (sel == 7) ? OP_JALR : 7'b0010011;
            f3  = 3'($urandom_range(0, 7));
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            pc  = $urandom & 32'hFFFFFFFC;
            imm = $urandom;
            pd  = ($urandom_range(0, 3) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
            rob = 5'($urandom);
            model(opc, f3, a, b, pc, imm, pd, m_taken, m_tgt, m_pdv, m_link);
            issue(opc, f3, a, b, pc, imm, pd, rob);
            expect_wb("rand", m_taken, m_tgt, m_pdv, pd, m_link, rob, $urandom_range(0, 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
